kernel_sequencer: RTL and testbench

KERNEL_SEQUENCER -- requirements
Module: kernel_sequencer

---
 rtl/kernel_sequencer.sv | 154 +++++++++++++++
 tb/tb_kernel_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_sequencer.sv
// Loads nine kernel words and three bias words, then steps the kernel-row
// select through bias, K1-3, K4-6, K7-9 for each requested output block.
module kernel_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_blocks,
    output logic [9*DATA_WIDTH-1:0] kernels,
    output logic [3*DATA_WIDTH-1:0] bias,
    output logic [1:0]              sel,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_first,
    output logic                    m_last,
    output logic                    loaded,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r;
    logic [3:0]       word_cnt_r;
    logic [CNT_W-1:0] blk_cnt_r;
    logic [1:0]       phase_r;
    logic             accept_s;
    logic [1:0]       phase_inc_s;

    assign accept_s    = s_valid & s_ready;
    assign phase_inc_s = phase_r + 2'd1;

    // Sequencer FSM with every output registered alongside the state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= IDLE;
            word_cnt_r <= 4'd0;
            blk_cnt_r  <= {CNT_W{1'b0}};
            phase_r    <= 2'd3;
            kernels    <= {(9*DATA_WIDTH){1'b0}};
            bias       <= {(3*DATA_WIDTH){1'b0}};
            s_ready    <= 1'b0;
            sel        <= 2'd0;
            m_valid    <= 1'b0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            loaded     <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            state_r    <= IDLE;
            word_cnt_r <= 4'd0;
            blk_cnt_r  <= {CNT_W{1'b0}};
            phase_r    <= 2'd3;
            s_ready    <= 1'b1;
            sel        <= 2'd0;
            m_valid    <= 1'b0;
            m_first    <= 1'b0;
            m_last     <= 1'b0;
            loaded     <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (accept_s) begin
                        for (int i = 0; i < 9; i++) begin
                            if (word_cnt_r == 4'(i)) begin
                                kernels[i*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end
                        end
                        for (int j = 0; j < 3; j++) begin
                            if (word_cnt_r == 4'(j + 9)) begin
                                bias[j*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                            end
                        end
                        if (word_cnt_r == 4'd11) begin
                            word_cnt_r <= 4'd0;
                            state_r    <= ARMED;
                            s_ready    <= 1'b0;
                            loaded     <= 1'b1;
                        end else begin
                            word_cnt_r <= word_cnt_r + 4'd1;
                        end
                    end
                end
                ARMED: begin
                    if (start) begin
                        if (n_blocks != {CNT_W{1'b0}}) begin
                            blk_cnt_r <= n_blocks;
                            phase_r   <= 2'd3;
                            state_r   <= RUN;
                            sel       <= 2'd3;
                            m_valid   <= 1'b1;
                            m_first   <= 1'b1;
                            m_last    <= 1'b0;
                        end else begin
                            state_r <= DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (m_ready) begin
                        if (phase_r == 2'd2) begin
                            blk_cnt_r <= blk_cnt_r - CNT_W'(1);
                            phase_r   <= 2'd3;
                            m_last    <= 1'b0;
                            if (blk_cnt_r == CNT_W'(1)) begin
                                state_r <= DONE;
                                done    <= 1'b1;
                                sel     <= 2'd0;
                                m_valid <= 1'b0;
                                m_first <= 1'b0;
                            end else begin
                                sel     <= 2'd3;
                                m_first <= 1'b1;
                            end
                        end else begin
                            // 3 wraps to 0 through the 2-bit increment
                            phase_r <= phase_inc_s;
                            sel     <= phase_inc_s;
                            m_first <= 1'b0;
                            m_last  <= (phase_inc_s == 2'd2);
                        end
                    end
                end
                DONE: begin
                    state_r <= ARMED;
                end
                default: begin
                    state_r <= IDLE;
                    s_ready <= 1'b0;
                    sel     <= 2'd0;
                    m_valid <= 1'b0;
                    m_first <= 1'b0;
                    m_last  <= 1'b0;
                    loaded  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed bench for kernel_sequencer: load, run, stall, zero count, abort, async reset.
module tb_kernel_sequencer;

    localparam int DW = 16;
    localparam int CW = 16;

    logic            clk;
    logic            rstn;
    logic            clear;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic            start;
    logic [CW-1:0]   n_blocks;
    logic [9*DW-1:0] kernels;
    logic [3*DW-1:0] bias;
    logic [1:0]      sel;
    logic            m_valid;
    logic            m_ready;
    logic            m_first;
    logic            m_last;
    logic            loaded;
    logic            done;

    int checks = 0;
    int errors = 0;
    logic [9*DW-1:0] exp_k;
    logic [3*DW-1:0] exp_b;

    kernel_sequencer #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .clear(clear),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .start(start), .n_blocks(n_blocks),
        .kernels(kernels), .bias(bias), .sel(sel),
        .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first), .m_last(m_last),
        .loaded(loaded), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int base);
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + i + 1);
            tick;
        end
        s_valid = 1'b0;
        for (int i = 0; i < 9; i++) exp_k[i*DW +: DW] = DW'(base + i + 1);
        for (int i = 0; i < 3; i++) exp_b[i*DW +: DW] = DW'(base + i + 10);
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({sel, m_valid, m_first, m_last, done, loaded, s_ready} !== 8'b0) begin
            $display("FAIL reset_outputs: got %b want 00000000",
                     {sel, m_valid, m_first, m_last, done, loaded, s_ready});
            errors++;
        end
        checks++;
        if (kernels !== '0 || bias !== '0) begin
            $display("FAIL reset_regs: kernels %h bias %h want 0", kernels, bias);
            errors++;
        end
        @(posedge clk);
        #2 rstn = 1'b1;
        tick;
        checks++;
        if (s_ready !== 1'b1 || loaded !== 1'b0) begin
            $display("FAIL reset_release: s_ready %b loaded %b want 1 0", s_ready, loaded);
            errors++;
        end
    endtask

    task automatic test_load;
        for (int i = 0; i < 12; i++) begin
            s_valid  = 1'b1;
            s_data   = DW'(i + 1);
            start    = (i == 11);
            n_blocks = 16'd1;
            tick;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 9; i++) exp_k[i*DW +: DW] = DW'(i + 1);
        exp_b = {16'd12, 16'd11, 16'd10};
        checks++;
        if (loaded !== 1'b1 || s_ready !== 1'b0) begin
            $display("FAIL load_armed: loaded %b s_ready %b want 1 0", loaded, s_ready);
            errors++;
        end
        checks++;
        if (kernels !== exp_k) begin
            $display("FAIL load_kernels: got %h want %h", kernels, exp_k);
            errors++;
        end
        checks++;
        if (bias !== exp_b) begin
            $display("FAIL load_bias: got %h want %h", bias, exp_b);
            errors++;
        end
        s_valid = 1'b1;
        s_data  = 16'hdead;
        tick;
        s_valid = 1'b0;
        checks++;
        if (kernels !== exp_k || bias !== exp_b || m_valid !== 1'b0 || done !== 1'b0) begin
            $display("FAIL load_ignore: kernels %h bias %h m_valid %b done %b want %h %h 0 0",
                     kernels, bias, m_valid, done, exp_k, exp_b);
            errors++;
        end
    endtask

    task automatic test_run;
        logic [1:0] es;
        n_blocks = 16'd2;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            es = 2'(i + 3);
            checks++;
            if (m_valid !== 1'b1 || sel !== es || m_first !== (es == 2'd3) ||
                m_last !== (es == 2'd2) || done !== 1'b0) begin
                $display("FAIL run_step%0d: valid %b sel %0d first %b last %b done %b want sel %0d",
                         i, m_valid, sel, m_first, m_last, done, es);
                errors++;
            end
            tick;
        end
        checks++;
        if (done !== 1'b1 || m_valid !== 1'b0 || sel !== 2'd0) begin
            $display("FAIL run_done: done %b m_valid %b sel %0d want 1 0 0", done, m_valid, sel);
            errors++;
        end
        tick;
        checks++;
        if (done !== 1'b0 || m_valid !== 1'b0 || loaded !== 1'b1 || s_ready !== 1'b0) begin
            $display("FAIL run_armed: done %b m_valid %b loaded %b s_ready %b want 0 0 1 0",
                     done, m_valid, loaded, s_ready);
            errors++;
        end
    endtask

    task automatic test_backpressure;
        n_blocks = 16'd1;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        checks++;
        if (sel !== 2'd1 || m_valid !== 1'b1) begin
            $display("FAIL bp_reach: sel %0d m_valid %b want 1 1", sel, m_valid);
            errors++;
        end
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (sel !== 2'd1 || m_valid !== 1'b1 || m_last !== 1'b0) begin
                $display("FAIL bp_hold%0d: sel %0d m_valid %b m_last %b want 1 1 0",
                         i, sel, m_valid, m_last);
                errors++;
            end
        end
        m_ready = 1'b1;
        tick;
        checks++;
        if (sel !== 2'd2 || m_valid !== 1'b1 || m_last !== 1'b1) begin
            $display("FAIL bp_resume: sel %0d m_valid %b m_last %b want 2 1 1", sel, m_valid, m_last);
            errors++;
        end
        tick;
        checks++;
        if (done !== 1'b1 || m_valid !== 1'b0) begin
            $display("FAIL bp_done: done %b m_valid %b want 1 0", done, m_valid);
            errors++;
        end
        tick;
    endtask

    task automatic test_zero_count;
        n_blocks = 16'd0;
        start    = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || m_valid !== 1'b0) begin
            $display("FAIL zero_done: done %b m_valid %b want 1 0", done, m_valid);
            errors++;
        end
        tick;
        checks++;
        if (done !== 1'b0 || m_valid !== 1'b0 || loaded !== 1'b1) begin
            $display("FAIL zero_after: done %b m_valid %b loaded %b want 0 0 1", done, m_valid, loaded);
            errors++;
        end
    endtask

    task automatic test_abort;
        n_blocks = 16'd3;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++;
        if (sel !== 2'd0 || m_valid !== 1'b1) begin
            $display("FAIL abort_reach: sel %0d m_valid %b want 0 1", sel, m_valid);
            errors++;
        end
        clear = 1'b1;
        start = 1'b1;
        tick;
        clear = 1'b0;
        start = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || loaded !== 1'b0 || s_ready !== 1'b1 || kernels !== exp_k) begin
            $display("FAIL abort_idle: m_valid %b loaded %b s_ready %b kernels %h want 0 0 1 %h",
                     m_valid, loaded, s_ready, kernels, exp_k);
            errors++;
        end
        load_words(100);
        checks++;
        if (kernels !== exp_k || bias !== exp_b || loaded !== 1'b1) begin
            $display("FAIL abort_reload: kernels %h bias %h loaded %b want %h %h 1",
                     kernels, bias, loaded, exp_k, exp_b);
            errors++;
        end
        n_blocks = 16'd1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || sel !== 2'(i + 3)) begin
                $display("FAIL abort_run%0d: m_valid %b sel %0d want 1 %0d", i, m_valid, sel, 2'(i + 3));
                errors++;
            end
            tick;
        end
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL abort_done: done %b want 1", done);
            errors++;
        end
        tick;
    endtask

    task automatic test_async_reset;
        n_blocks = 16'd2;
        m_ready  = 1'b1;
        start    = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({sel, m_valid, m_first, m_last, done, loaded, s_ready} !== 8'b0) begin
            $display("FAIL async_outputs: got %b want 00000000",
                     {sel, m_valid, m_first, m_last, done, loaded, s_ready});
            errors++;
        end
        checks++;
        if (kernels !== '0 || bias !== '0) begin
            $display("FAIL async_regs: kernels %h bias %h want 0", kernels, bias);
            errors++;
        end
        #3 rstn = 1'b1;
        tick;
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            $display("FAIL async_release: s_ready %b m_valid %b want 1 0", s_ready, m_valid);
            errors++;
        end
    endtask

    initial begin
        rstn     = 1'b0;
        clear    = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        start    = 1'b0;
        n_blocks = '0;
        m_ready  = 1'b0;
        exp_k    = '0;
        exp_b    = '0;
        test_reset;
        test_load;
        test_run;
        test_backpressure;
        test_zero_count;
        test_abort;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
